// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and arbiter FSM state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_OR = 3'b010;
  localparam logic [2:0] ALU_OP_ILLEGAL = 3'b011;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/ALU.sv
// ALU: 32-bit combinational ALU; Overflow only for signed ADD/SUB
module ALU
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUctr,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Overflow
);
  logic [31:0] sum, diff;
  assign sum = A + B;
  assign diff = A - B;
  always_comb begin
    Result = (ALUctr == ALU_ADDU || ALUctr == ALU_ADD) ? sum :
             (ALUctr == ALU_OR) ? (A | B) :
             (ALUctr == ALU_SUBU || ALUctr == ALU_SUB) ? diff :
             (ALUctr == ALU_SLTU) ? {31'b0, A < B} :
             (ALUctr == ALU_SLT) ? {31'b0, $signed(A) < $signed(B)} : 32'b0;
    Overflow = (ALUctr == ALU_ADD) ? (A[31] == B[31] && sum[31] != A[31]) :
               (ALUctr == ALU_SUB) ? (A[31] != B[31] && diff[31] != A[31]) : 1'b0;
  end
  assign Zero = Result == 32'b0;
endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin pick of the first valid index at or after ptr
module alu_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [NREQ-1:0] rot;
  int j;
  assign rot = NREQ'({valid, valid} >> ptr);
  assign any = |valid;
  // walk offsets from far to near so the nearest valid offset is the one left standing
  always_comb begin
    idx = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      idx = |(rot & (NREQ'(1) << k)) ? IDW'(j) : idx;
    end
  end
  assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one ALU among NREQ requesters, tagged response channel.
// Optional ALU_OVF_STICKY_EN adds per-requester sticky overflow flags (ovf_sticky/ovf_clr).
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_zero,
  output logic               rsp_ovf,
  output logic               rsp_err
`ifdef ALU_OVF_STICKY_EN
  ,
  output logic [NREQ-1:0]    ovf_sticky,
  input  logic [NREQ-1:0]    ovf_clr
`endif
);
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, g_idx;
  logic [NREQ-1:0] g_oh;
  logic any;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic [2:0] op_q, op_d;
  logic zero_q, zero_d, ovf_q, ovf_d, err_q, err_d, alu_zero, alu_ovf;

  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid(req_valid), .ptr(ptr_q), .grant(g_oh), .idx(g_idx), .any(any)
  );

  ALU u_alu (
    .A(a_q), .B(b_q), .ALUctr(op_q), .Result(alu_res), .Zero(alu_zero), .Overflow(alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    err_d = err_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: if (any) begin
        req_ready = g_oh;
        a_d = 32'(req_a >> (int'(g_idx) * 32));
        b_d = 32'(req_b >> (int'(g_idx) * 32));
        op_d = 3'(req_op >> (int'(g_idx) * 3));
        id_d = g_idx;
        ptr_d = (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + IDW'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        err_d = op_q == ALU_OP_ILLEGAL;
        res_d = err_d ? '0 : alu_res;
        zero_d = err_d ? 1'b1 : alu_zero;
        ovf_d = err_d ? 1'b0 : alu_ovf;
        state_d = S_RESP;
      end
      default: state_d = rsp_ready ? S_IDLE : state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign rsp_valid = state_q == S_RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_zero = zero_q;
  assign rsp_ovf = ovf_q;
  assign rsp_err = err_q;

`ifdef ALU_OVF_STICKY_EN
  logic [NREQ-1:0] sticky_q, sticky_d;
  // set is OR-ed after the clear mask so a same-cycle set wins
  assign sticky_d = (sticky_q & ~ovf_clr) |
                    ((state_q == S_RESP && rsp_ready && ovf_q) ? NREQ'(1) << id_q : '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
  assign ovf_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed scoreboard bench for the round-robin ALU arbiter
module tb_alu_rr_arbiter;
  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [5:0] req_op;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_err;
  logic [31:0] rsp_result;
`ifdef ALU_OVF_STICKY_EN
  logic [1:0] ovf_sticky, ovf_clr;
`endif

  int checks = 0;
  int failures = 0;
  int mptr = 0;
  exp_t sb[$];
  time rsp_t = 0;
  time prev_t = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
`ifdef ALU_OVF_STICKY_EN
    , .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t e;
    logic [31:0] r;
    logic o;
    o = 1'b0;
    case (op)
      3'b000: r = a + b;
      3'b001: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b010: r = a | b;
      3'b100: r = a - b;
      3'b101: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b110: r = {31'b0, a < b};
      3'b111: r = {31'b0, $signed(a) < $signed(b)};
      default: r = 32'b0;
    endcase
    e.id = id[0];
    e.r = r;
    e.z = r == 32'b0;
    e.o = o;
    e.e = op == 3'b011;
    return e;
  endfunction

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++) if (v[(p + k) % 2]) return (p + k) % 2;
    return 0;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3] = op;
  endtask

  // one accept/execute/respond transaction; bp = cycles of response backpressure
  task automatic run_op(input logic [1:0] vmask, input bit keep, input int bp);
    int g, n;
    exp_t e;
    @(negedge clk);
    req_valid = vmask;
    #1;
    g = pick(vmask, mptr);
    chk("grant", {30'b0, req_ready}, 32'(1 << g));
    sb.push_back(model(g, req_a[32*g +: 32], req_b[32*g +: 32], req_op[3*g +: 3]));
    mptr = (g + 1) % 2;
    @(negedge clk);
    if (!keep) req_valid = '0;
    chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("exec_req_ready", {30'b0, req_ready}, 32'd0);
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd2);
    rsp_t = $time;
    e = sb.pop_front();
    for (int c = 0; c <= bp; c++) begin
      if (c > 0) @(negedge clk);
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
      chk("rsp_result", rsp_result, e.r);
      chk("rsp_flags", {29'b0, rsp_zero, rsp_ovf, rsp_err}, {29'b0, e.z, e.o, e.e});
      if (c > 0) chk("bp_req_ready", {30'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
`ifdef ALU_OVF_STICKY_EN
    ovf_clr = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_flags", {29'b0, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    rst = 1'b0;

    set_op(0, 32'd5, 32'd3, 3'b100);
    run_op(2'b01, 1'b0, 0);
    set_op(1, 32'hFFFFFFFF, 32'd0, 3'b111);
    run_op(2'b10, 1'b0, 0);
    set_op(0, 32'hFFFFFFFF, 32'd0, 3'b110);
    run_op(2'b01, 1'b0, 0);
    set_op(1, 32'd7, 32'd9, 3'b011);
    run_op(2'b10, 1'b0, 0);

    set_op(0, 32'd10, 32'd20, 3'b000);
    set_op(1, 32'h000000F0, 32'h0000000F, 3'b010);
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 1'b1, 0);
      chk("fair_id", {31'b0, rsp_id}, 32'(i % 2));
      if (i > 0) chk("fair_gap", 32'(rsp_t - prev_t), 32'd30);
      prev_t = rsp_t;
    end
    req_valid = '0;

    set_op(0, 32'h7FFFFFFF, 32'd1, 3'b001);
    set_op(1, 32'h7FFFFFFF, 32'd1, 3'b000);
    run_op(2'b11, 1'b1, 5);
`ifdef ALU_OVF_STICKY_EN
    chk("sticky_set", {30'b0, ovf_sticky}, 32'd1);
`endif
    run_op(2'b11, 1'b0, 0);
`ifdef ALU_OVF_STICKY_EN
    @(negedge clk);
    ovf_clr = 2'b01;
    @(negedge clk);
    ovf_clr = '0;
    chk("sticky_clr", {30'b0, ovf_sticky}, 32'd0);
`endif

    set_op(0, 32'd1, 32'd2, 3'b000);
    set_op(1, 32'd3, 32'd4, 3'b101);
    @(negedge clk);
    req_valid = 2'b01;
    #1 chk("rst_op_grant", {30'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1 chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    mptr = 0;
    run_op(2'b11, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
